// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the pipeline-stage registers:
//   - pstage_state_t : data-memory wait state of a pipeline stage (RUN / MISS)
//   - ifid_t, idex_t, exmem_t, memwb_t : per-boundary payload structs. Callers
//     pack one of these into in_data and unpack out_data at the
//     instantiation site, so DATA_W is $bits() of the chosen struct.
//   - wait_cnt_width() : width of the internal consecutive-miss counter.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } pstage_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifid_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        ren;
        logic        wen;
        logic        reg_wen;
    } idex_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_out;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic [2:0]  mem_size;
        logic        ren;
        logic        wen;
        logic        reg_wen;
    } exmem_t;

    typedef struct packed {
        logic [31:0] mem_data;
        logic [31:0] alu_out;
        logic [4:0]  rd;
        logic        reg_wen;
        logic        mem_to_reg;
    } memwb_t;

    // Enough bits to hold the value timeout_cycles; a disabled timeout (0)
    // still needs a one-bit vector so the counter declaration stays legal.
    function automatic int wait_cnt_width(input int timeout_cycles);
        if (timeout_cycles > 0) begin
            return $clog2(timeout_cycles + 1);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   in  1  clock, rising edge
//   rst_n in  1  asynchronous reset, active low (count -> 0)
//   clr   in  1  synchronous clear; wins over inc
//   inc   in  1  add one this cycle unless already at all-ones
//   cnt   out W  current count (registered)
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, then increment only while below the ceiling.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_latch.sv
// -----------------------------------------------------------------------------
// pipe_stage_latch
// Generic pipeline-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid
// bit, hazard-unit advance enable, bubble-inserting flush, and a data-memory
// wait machine that freezes the stage while its own access is outstanding.
// Ports:
//   CLK, nRST    clock (rising edge) / asynchronous active-low reset
//   en           advance enable from the hazard unit (0 = hold)
//   flush        replace the latched entry with a bubble
//   in_valid     upstream entry valid
//   in_memreq    upstream entry reads or writes data memory
//   in_data      upstream payload (packed stage struct)
//   dhit         data cache hit/ack for the latched request
//   clr_cnt      synchronous clear of miss_cycles
//   out_valid    latched entry valid
//   out_data     latched payload
//   mem_req      latched entry is valid and accesses data memory
//   mem_stall    combinational: request visible and not yet acknowledged
//   miss_cycles  saturating number of cycles spent with mem_stall=1
//   timeout      sticky: a single wait lasted TIMEOUT MISS cycles
// -----------------------------------------------------------------------------
module pipe_stage_latch
    import cpu_types_pkg::*;
#(
    parameter int DATA_W     = 200,
    parameter int FLUSH_ZERO = 1,
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              en,
    input  logic              flush,
    input  logic              in_valid,
    input  logic              in_memreq,
    input  logic [DATA_W-1:0] in_data,
    input  logic              dhit,
    input  logic              clr_cnt,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              mem_req,
    output logic              mem_stall,
    output logic [CNT_W-1:0]  miss_cycles,
    output logic              timeout
);

    localparam int              WAIT_W     = wait_cnt_width(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam bit              TIMEOUT_EN = (TIMEOUT > 0);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              memreq_q,    memreq_d;
    pstage_state_t     state_q,     state_d;
    logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
    logic              timeout_q,   timeout_d;

    logic              mem_req_s;
    logic              mem_stall_s;

    // The stall is combinational so that the stage and everything upstream
    // freeze in the very cycle the request becomes visible; a same-cycle
    // dhit therefore never costs a cycle.
    assign mem_req_s   = out_valid_q & memreq_q;
    assign mem_stall_s = mem_req_s & ~dhit;

    // Next-state logic for the payload, wait machine and timeout flag.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        memreq_d    = memreq_q;
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;

        // An outstanding access outranks flush and en: dropping it would
        // lose a store or return load data to the wrong entry.
        if (mem_stall_s) begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            memreq_d    = memreq_q;
        end else if (flush) begin
            out_valid_d = 1'b0;
            memreq_d    = 1'b0;
            if (FLUSH_ZERO != 0) begin
                out_data_d = {DATA_W{1'b0}};
            end else begin
                out_data_d = out_data_q;
            end
        end else if (en) begin
            out_valid_d = in_valid;
            out_data_d  = in_data;
            // A bubble must never reach data memory.
            memreq_d    = in_valid & in_memreq;
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
            memreq_d    = memreq_q;
        end

        case (state_q)
            RUN: begin
                if (mem_stall_s) begin
                    state_d = MISS;
                end else begin
                    state_d = RUN;
                end
            end
            MISS: begin
                if (dhit) begin
                    state_d = RUN;
                end else begin
                    state_d = MISS;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // The wait counter only measures the current MISS episode; it parks
        // at the limit instead of wrapping, since timeout is already sticky.
        if (state_q == MISS) begin
            if (wait_cnt_q != WAIT_LIMIT) begin
                wait_cnt_d = wait_cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
            end else begin
                wait_cnt_d = wait_cnt_q;
            end
        end else begin
            wait_cnt_d = {WAIT_W{1'b0}};
        end

        if (TIMEOUT_EN && (state_q == MISS) && (wait_cnt_d == WAIT_LIMIT)) begin
            timeout_d = 1'b1;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // Stage register block.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            memreq_q    <= 1'b0;
            state_q     <= RUN;
            wait_cnt_q  <= {WAIT_W{1'b0}};
            timeout_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            memreq_q    <= memreq_d;
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_miss_cnt (
        .clk   (CLK),
        .rst_n (nRST),
        .clr   (clr_cnt),
        .inc   (mem_stall_s),
        .cnt   (miss_cycles)
    );

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mem_req   = mem_req_s;
    assign mem_stall = mem_stall_s;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_pipe_stage_latch.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_latch
// Two instances share one stimulus stream: "a" uses the default parameters,
// "b" is small (DATA_W=8, CNT_W=2, TIMEOUT=5, FLUSH_ZERO=0) so saturation,
// timeout and flush-keeps-data are reachable. A behavioural model tracks
// each instance from the stage rules; the wait state is modelled as "the
// previous cycle stalled", and the timeout as a run length of such cycles.
// -----------------------------------------------------------------------------
module tb_pipe_stage_latch;

    localparam int DW  = 200;
    localparam int SDW = 8;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          en, flush, in_valid, in_memreq, dhit, clr_cnt;
    logic [DW-1:0] in_data;

    logic          a_out_valid, a_mem_req, a_mem_stall, a_timeout;
    logic [DW-1:0] a_out_data;
    logic [15:0]   a_miss;
    logic          b_out_valid, b_mem_req, b_mem_stall, b_timeout;
    logic [SDW-1:0] b_out_data;
    logic [1:0]    b_miss;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state, index 0 = a, 1 = b.
    logic          m_valid[2];
    logic          m_memreq[2];
    logic [DW-1:0] m_data[2];
    int unsigned   m_miss[2];
    logic          m_to[2];
    logic          m_prev_stall[2];
    int unsigned   m_streak[2];

    always #5 CLK = ~CLK;

    pipe_stage_latch dut_a (
        .CLK (CLK), .nRST (nRST), .en (en), .flush (flush),
        .in_valid (in_valid), .in_memreq (in_memreq), .in_data (in_data),
        .dhit (dhit), .clr_cnt (clr_cnt),
        .out_valid (a_out_valid), .out_data (a_out_data), .mem_req (a_mem_req),
        .mem_stall (a_mem_stall), .miss_cycles (a_miss), .timeout (a_timeout)
    );

    pipe_stage_latch #(
        .DATA_W (SDW), .FLUSH_ZERO (0), .CNT_W (2), .TIMEOUT (5)
    ) dut_b (
        .CLK (CLK), .nRST (nRST), .en (en), .flush (flush),
        .in_valid (in_valid), .in_memreq (in_memreq), .in_data (in_data[SDW-1:0]),
        .dhit (dhit), .clr_cnt (clr_cnt),
        .out_valid (b_out_valid), .out_data (b_out_data), .mem_req (b_mem_req),
        .mem_stall (b_mem_stall), .miss_cycles (b_miss), .timeout (b_timeout)
    );

    function automatic int unsigned cnt_max(input int i);
        return (i == 0) ? 32'd65535 : 32'd3;
    endfunction

    function automatic int unsigned timeout_lim(input int i);
        return (i == 0) ? 32'd1024 : 32'd5;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i]      = 1'b0;
            m_memreq[i]     = 1'b0;
            m_data[i]       = '0;
            m_miss[i]       = 0;
            m_to[i]         = 1'b0;
            m_prev_stall[i] = 1'b0;
            m_streak[i]     = 0;
        end
    endtask

    // Outputs must all be zero while nRST is low, without any clock edge.
    task automatic check_reset(input string ph);
        chk({ph, ":a_valid"}, DW'(a_out_valid), DW'(0));
        chk({ph, ":a_data"},  a_out_data,       DW'(0));
        chk({ph, ":a_req"},   DW'(a_mem_req),   DW'(0));
        chk({ph, ":a_stall"}, DW'(a_mem_stall), DW'(0));
        chk({ph, ":a_miss"},  DW'(a_miss),      DW'(0));
        chk({ph, ":a_to"},    DW'(a_timeout),   DW'(0));
        chk({ph, ":b_valid"}, DW'(b_out_valid), DW'(0));
        chk({ph, ":b_data"},  DW'(b_out_data),  DW'(0));
        chk({ph, ":b_stall"}, DW'(b_mem_stall), DW'(0));
        chk({ph, ":b_miss"},  DW'(b_miss),      DW'(0));
        chk({ph, ":b_to"},    DW'(b_timeout),   DW'(0));
    endtask

    task automatic check_all(input string ph);
        logic req0, req1;
        req0 = m_valid[0] & m_memreq[0];
        req1 = m_valid[1] & m_memreq[1];
        chk({ph, ":a_valid"}, DW'(a_out_valid), DW'(m_valid[0]));
        chk({ph, ":a_data"},  a_out_data,       m_data[0]);
        chk({ph, ":a_req"},   DW'(a_mem_req),   DW'(req0));
        chk({ph, ":a_stall"}, DW'(a_mem_stall), DW'(req0 & ~dhit));
        chk({ph, ":a_miss"},  DW'(a_miss),      DW'(m_miss[0]));
        chk({ph, ":a_to"},    DW'(a_timeout),   DW'(m_to[0]));
        chk({ph, ":b_valid"}, DW'(b_out_valid), DW'(m_valid[1]));
        chk({ph, ":b_data"},  DW'(b_out_data),  DW'(m_data[1][SDW-1:0]));
        chk({ph, ":b_req"},   DW'(b_mem_req),   DW'(req1));
        chk({ph, ":b_stall"}, DW'(b_mem_stall), DW'(req1 & ~dhit));
        chk({ph, ":b_miss"},  DW'(b_miss),      DW'(m_miss[1]));
        chk({ph, ":b_to"},    DW'(b_timeout),   DW'(m_to[1]));
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            logic st;
            logic in_miss;
            st      = m_valid[i] & m_memreq[i] & ~dhit;
            in_miss = m_prev_stall[i];
            if (!st) begin
                if (flush) begin
                    m_valid[i]  = 1'b0;
                    m_memreq[i] = 1'b0;
                    if (i == 0) m_data[i] = '0;
                end else if (en) begin
                    m_valid[i]  = in_valid;
                    m_memreq[i] = in_valid & in_memreq;
                    m_data[i]   = (i == 0) ? in_data : {{(DW-SDW){1'b0}}, in_data[SDW-1:0]};
                end
            end
            if (clr_cnt) m_miss[i] = 0;
            else if (st && (m_miss[i] < cnt_max(i))) m_miss[i] = m_miss[i] + 1;
            if (in_miss) begin
                m_streak[i] = m_streak[i] + 1;
                if (m_streak[i] >= timeout_lim(i)) m_to[i] = 1'b1;
            end else begin
                m_streak[i] = 0;
            end
            m_prev_stall[i] = st;
        end
    endtask

    // Inputs are applied at the falling edge; check, model, then clock.
    task automatic cycle(input string ph);
        #1;
        check_all(ph);
        model_step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic rand_data();
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        in_data = t[DW-1:0];
    endtask

    initial begin
        int hit_pct;
        nRST = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; in_memreq = 1'b1;
        dhit = 1'b0; clr_cnt = 1'b0; in_data = {25{8'h5A}};
        #2 nRST = 1'b0;
        #1 check_reset("reset0");
        model_reset();
        @(negedge CLK);
        nRST = 1'b1;

        // Pass-through, one-cycle latency.
        en = 1'b1; in_valid = 1'b1; in_memreq = 1'b0; dhit = 1'b0; in_data = {25{8'hA5}};
        cycle("pass_in");
        en = 1'b0; in_valid = 1'b0;
        #1;
        chk("pass_data",  a_out_data,       {25{8'hA5}});
        chk("pass_valid", DW'(a_out_valid), DW'(1));
        chk("pass_stall", DW'(a_mem_stall), DW'(0));

        // Miss: three stalled cycles, new input and a flush are ignored.
        en = 1'b1; in_valid = 1'b1; in_memreq = 1'b1; in_data = {25{8'h3C}};
        cycle("miss_in");
        in_data = {25{8'hC3}};
        cycle("miss_w1");
        flush = 1'b1;
        cycle("miss_w2");
        flush = 1'b0;
        cycle("miss_w3");
        dhit = 1'b1; in_memreq = 1'b0;
        #1;
        chk("miss_cnt",   DW'(a_miss),      DW'(3));
        chk("miss_hold",  a_out_data,       {25{8'h3C}});
        chk("miss_stall", DW'(a_mem_stall), DW'(0));
        cycle("miss_hit");

        // Flush beats en with no stall pending.
        flush = 1'b1; en = 1'b1; in_valid = 1'b1; in_data = {25{8'h77}};
        cycle("flush");
        flush = 1'b0;
        #1;
        chk("flush_valid",  DW'(a_out_valid), DW'(0));
        chk("flush_zero",   a_out_data,       DW'(0));
        chk("flush_keep_b", DW'(b_out_data),  DW'(8'hC3));

        // Saturation and sticky timeout.
        clr_cnt = 1'b1; in_memreq = 1'b1; dhit = 1'b1; rand_data();
        cycle("sat_load");
        clr_cnt = 1'b0; dhit = 1'b0;
        for (int k = 0; k < 8; k++) begin
            rand_data();
            cycle("sat_wait");
        end
        #1;
        chk("sat_b_miss", DW'(b_miss),    DW'(3));
        chk("sat_b_to",   DW'(b_timeout), DW'(1));
        chk("sat_a_miss", DW'(a_miss),    DW'(8));
        chk("sat_a_to",   DW'(a_timeout), DW'(0));
        clr_cnt = 1'b1; dhit = 1'b1; in_memreq = 1'b0;
        cycle("sat_clr");
        clr_cnt = 1'b0;
        #1;
        chk("clr_b_miss", DW'(b_miss),    DW'(0));
        chk("clr_b_to",   DW'(b_timeout), DW'(1));

        // Invalid entry never requests memory.
        en = 1'b1; in_valid = 1'b0; in_memreq = 1'b1; dhit = 1'b0;
        cycle("inv_load");
        #1;
        chk("inv_req",   DW'(a_mem_req),   DW'(0));
        chk("inv_stall", DW'(a_mem_stall), DW'(0));
        cycle("inv_hold");

        // Reset in the middle of a miss aborts the wait.
        in_valid = 1'b1; in_memreq = 1'b1; dhit = 1'b0;
        cycle("rm_load");
        cycle("rm_w1");
        cycle("rm_w2");
        #2 nRST = 1'b0;
        #1 check_reset("rm_rst");
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        dhit = 1'b1;
        cycle("rm_after1");
        cycle("rm_after2");

        // Randomised traffic with bursty hit rate.
        hit_pct = 70;
        for (int n = 0; n < 400; n++) begin
            if ((n % 50) == 0) hit_pct = (hit_pct == 70) ? 15 : 70;
            en        = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 7) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_memreq = ($urandom_range(0, 1) == 1);
            dhit      = ($urandom_range(0, 99) < hit_pct);
            clr_cnt   = ($urandom_range(0, 31) == 0);
            rand_data();
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
